// File: rtl/alu_flag_latch.sv
// ALU flag latch: derives {C,N,Z} from an ALU result and shows each accepted
// result for HOLD_CYCLES cycles, with a one-entry buffer for a result arriving mid-hold.
module alu_flag_latch #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned HOLD_CYCLES = 50_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] result,
  input  logic             carry_in,
  output logic [2:0]       flags_C_N_Z,
  output logic [2:0]       flags_raw,
  output logic             busy
);

  localparam int unsigned      CNT_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             pend_valid;
  logic [WIDTH-1:0] pend_result;
  logic             pend_carry;

  logic       xfer;
  logic [2:0] in_raw;
  logic [2:0] pend_raw;

  function automatic logic [2:0] derive(input logic [WIDTH-1:0] r, input logic c);
    return {c, r[WIDTH-1], (r == '0)};
  endfunction

  // Priority C > N > Z; no flag set blanks the display.
  function automatic logic [2:0] onehot(input logic [2:0] raw);
    logic [2:0] code;
    code = 3'b000;
    if (raw[2])      code = 3'b100;
    else if (raw[1]) code = 3'b010;
    else if (raw[0]) code = 3'b001;
    return code;
  endfunction

  assign in_ready = ~pend_valid;
  assign busy     = (state == HOLD);
  assign xfer     = in_valid & ~pend_valid;
  assign in_raw   = derive(result, carry_in);
  assign pend_raw = derive(pend_result, pend_carry);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      pend_valid  <= 1'b0;
      pend_result <= '0;
      pend_carry  <= 1'b0;
      flags_C_N_Z <= 3'b000;
      flags_raw   <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            flags_raw   <= in_raw;
            flags_C_N_Z <= onehot(in_raw);
            cnt         <= '0;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (cnt != CNT_LAST) begin
            cnt <= cnt + CNT_W'(1);
            if (xfer) begin
              pend_result <= result;
              pend_carry  <= carry_in;
              pend_valid  <= 1'b1;
            end
          end else if (pend_valid) begin
            flags_raw   <= pend_raw;
            flags_C_N_Z <= onehot(pend_raw);
            pend_valid  <= 1'b0;
            cnt         <= '0;
          end else if (xfer) begin
            // Buffer is empty, so the new result goes straight to the display.
            flags_raw   <= in_raw;
            flags_C_N_Z <= onehot(in_raw);
            cnt         <= '0;
          end else begin
            flags_raw   <= 3'b000;
            flags_C_N_Z <= 3'b000;
            cnt         <= '0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
